// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 16x-oversampled UART receiver for 8N1 frames, LSB first.
// Holds each byte with rx_complete_flag until the controller acknowledges,
// and reports sticky framing / overrun errors.
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit; otherwise parity_error is tied low.
module uart_rx_frame #(
  parameter int OVERSAMPLE = 16,
  parameter int DEB_LEN    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [9:0] baudselect,
  input  logic       debounce_en,
  input  logic       rx_complete_del_flag,
  output logic [7:0] uart_data,
  output logic       rx_complete_flag,
  output logic       frame_error,
  output logic       overrun,
  output logic       parity_error
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int DW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam logic [SW-1:0] S_HALF   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_ZERO   = SW'(0);
  localparam logic [SW-1:0] S_ONE    = SW'(1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_LEN - 1);
  localparam logic [DW-1:0] DEB_ZERO = DW'(0);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } state_e;

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    return ~(^data ^ par);
  endfunction
`endif

  state_e          state_q, state_d;
  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  logic            filt_q, filt_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [9:0]      tick_cnt_q, tick_cnt_d;
  logic [9:0]      period_q, period_d;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      uart_data_q, uart_data_d;
  logic            flag_q, flag_d;
  logic            fe_q, fe_d;
  logic            ov_q, ov_d;

  logic            line_s, tick_s, half_s, sample_s, start_det_s, stop_eval_s;
  logic [9:0]      eff_period_s;
  logic            par_ok_s, deliver_s, ov_set_s, fe_set_s;

  assign line_s       = debounce_en ? filt_q : sync2_q;
  assign eff_period_s = (baudselect < 10'd2) ? 10'd2 : baudselect;
  assign tick_s       = (tick_cnt_q == (period_q - 10'd1));
  assign half_s       = tick_s && (s_q == S_HALF);
  assign sample_s     = tick_s && (s_q == S_LAST);
  assign start_det_s  = (state_q == ST_IDLE) && !line_s;
  assign stop_eval_s  = (state_q == ST_STOP) && sample_s;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic pe_q, pe_d;
  logic pe_set_s;
  assign par_ok_s     = even_parity_ok(shreg_q, par_q);
  assign pe_set_s     = stop_eval_s && !par_ok_s;
  assign parity_error = pe_q;
`else
  assign par_ok_s     = 1'b1;
  assign parity_error = 1'b0;
`endif

  // A good frame is delivered if the slot is free or being acknowledged now.
  assign deliver_s = stop_eval_s && line_s && par_ok_s && (!flag_q || rx_complete_del_flag);
  assign ov_set_s  = stop_eval_s && line_s && par_ok_s && flag_q && !rx_complete_del_flag;
  assign fe_set_s  = stop_eval_s && !line_s;

  // Synchronizer and glitch filter next-state.
  always_comb begin
    sync1_d   = rx;
    sync2_d   = sync1_q;
    filt_d    = filt_q;
    deb_cnt_d = deb_cnt_q;
    if (!debounce_en) begin
      filt_d    = sync2_q;
      deb_cnt_d = DEB_ZERO;
    end else if (sync2_q != filt_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        filt_d    = sync2_q;
        deb_cnt_d = DEB_ZERO;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_ONE;
      end
    end else begin
      deb_cnt_d = DEB_ZERO;
    end
  end

  // Synchronizer and glitch filter registers; preset to the idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      filt_q    <= 1'b1;
      deb_cnt_q <= DEB_ZERO;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      filt_q    <= filt_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = line_s ? ST_IDLE : ST_START;
      ST_START: begin
        if (half_s) begin
          state_d = line_s ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (sample_s && (bit_idx_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: state_d = sample_s ? ST_STOP : ST_PARITY;
`endif
      ST_STOP:  state_d = sample_s ? ST_IDLE : ST_STOP;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Tick generator, sample counter and shift register next-state.
  always_comb begin
    if (start_det_s || tick_s) begin
      tick_cnt_d = 10'd0;
    end else begin
      tick_cnt_d = tick_cnt_q + 10'd1;
    end
    period_d  = tick_s ? eff_period_s : period_q;
    s_d       = s_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        s_d       = S_ZERO;
        bit_idx_d = 3'd0;
      end
      ST_START: begin
        if (half_s) begin
          s_d       = S_ZERO;
          bit_idx_d = 3'd0;
        end else begin
          s_d = tick_s ? (s_q + S_ONE) : s_q;
        end
      end
      ST_DATA: begin
        if (sample_s) begin
          s_d       = S_ZERO;
          shreg_d   = {line_s, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          s_d = tick_s ? (s_q + S_ONE) : s_q;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (sample_s) begin
          s_d   = S_ZERO;
          par_d = line_s;
        end else begin
          s_d = tick_s ? (s_q + S_ONE) : s_q;
        end
      end
`endif
      ST_STOP: begin
        if (sample_s) begin
          s_d = S_ZERO;
        end else begin
          s_d = tick_s ? (s_q + S_ONE) : s_q;
        end
      end
      default: begin
        s_d       = S_ZERO;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  // Output next-state: acknowledge clears, new events set (set dominates).
  always_comb begin
    uart_data_d = deliver_s ? shreg_q : uart_data_q;
    flag_d      = deliver_s ? 1'b1 : (rx_complete_del_flag ? 1'b0 : flag_q);
    fe_d        = fe_set_s  ? 1'b1 : (rx_complete_del_flag ? 1'b0 : fe_q);
    ov_d        = ov_set_s  ? 1'b1 : (rx_complete_del_flag ? 1'b0 : ov_q);
`ifdef UART_RX_PARITY_EN
    pe_d        = pe_set_s  ? 1'b1 : (rx_complete_del_flag ? 1'b0 : pe_q);
`endif
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q  <= 10'd0;
      period_q    <= eff_period_s;
      s_q         <= S_ZERO;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'd0;
      uart_data_q <= 8'd0;
      flag_q      <= 1'b0;
      fe_q        <= 1'b0;
      ov_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q       <= 1'b0;
      pe_q        <= 1'b0;
`endif
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      period_q    <= period_d;
      s_q         <= s_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      uart_data_q <= uart_data_d;
      flag_q      <= flag_d;
      fe_q        <= fe_d;
      ov_q        <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_q       <= par_d;
      pe_q        <= pe_d;
`endif
    end
  end

  assign uart_data        = uart_data_q;
  assign rx_complete_flag = flag_q;
  assign frame_error      = fe_q;
  assign overrun          = ov_q;

endmodule
